shift_operand_stage: RTL and testbench
======================================

# shift_operand_stage

Decode/execute pipeline register for the shift datapath. Captures the shift operation, immediate or register-specified shift amount and the operand register each cycle. In the execute cycle it forwards the operand from EX/MEM or MEM/WB and drives the shifter's control, shamt and DATA inputs. It also detects load-use hazards against the instruction it holds and inserts a one-cycle bubble.

## Interface
Parameters:
- WIDTH, 32: datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; register contents frozen.
- flush  in  1  branch flush; captured instruction discarded.
- in_valid  in  1  decode holds a valid instruction.
- in_control  in  2  shift type (00 LSL, 01 LSR, 10 ASR, 11 RR).
- in_shamt_imm  in  5  immediate shift amount.
- in_shamt_reg  in  1  1 = shift amount from Rs[7:0].
- in_rm_addr, in_rs_addr  in  4 each  source register numbers.
- in_rm_data, in_rs_data  in  WIDTH each  register-file read data.
- in_is_load, in_rd  in  1, 4  decode instruction is a load / its destination.
- exm_wr, exm_rd, exm_result  in  1, 4, WIDTH  EX/MEM writeback info.
- mwb_wr, mwb_rd, mwb_result  in  1, 4, WIDTH  MEM/WB writeback info.
- out_valid  out  1  EX holds a valid instruction.
- sh_control  out  2  to shifter control.
- sh_shamt  out  5  to shifter shamt.
- sh_data  out  WIDTH  to shifter DATA.
- lu_stall  out  1  load-use hazard; decode and fetch must hold.

## Operation
- Register fields: valid, control, shamt_imm, shamt_reg, rm/rs addr, rm/rs data, is_load, rd.
- Update priority at each edge: flush > stall > lu_stall > normal.
  - flush: valid <- 0.
  - stall: all fields hold.
  - lu_stall: valid <- 0 (bubble). The other fields are don't-care.
  - normal: all fields load from decode inputs.
- Capture bypass: on load, if mwb_wr and mwb_rd equals an in_*_addr, the captured data is mwb_result, not the register-file value.
- Execute-side forwarding is combinational from the held fields, per operand Rm and Rs:
  - If exm_wr and exm_rd == addr: use exm_result.
  - Else if mwb_wr and mwb_rd == addr: use mwb_result.
  - Else: use the held data.
  - EX/MEM has priority over MEM/WB.
  - Address 15 (PC) is never forwarded.
- Shift amount:
  - shamt_reg = 0: sh_shamt = shamt_imm, sh_data = forwarded Rm.
  - shamt_reg = 1: let n = forwarded Rs[7:0].
    - n < 32: sh_shamt = n[4:0], sh_data = Rm.
    - n >= 32, LSL or LSR: sh_shamt = 0, sh_data = 0.
    - n >= 32, ASR: sh_shamt = 31, sh_data = Rm.
    - RR: sh_shamt = n[4:0] for any n.
- lu_stall = valid & is_load & in_valid & (rd == in_rm_addr | (in_shamt_reg & rd == in_rs_addr)). It is forced to 0 while flush is asserted.
- Outputs when valid = 0:
  - sh_control, sh_shamt, sh_data = 0.
  - out_valid = 0.

## Timing
- Reset: all fields cleared, asynchronously. out_valid, sh_control, sh_shamt, sh_data and lu_stall are all 0.
- Reset release is synchronous to the clk edge. Reset asserted mid-operation discards the held instruction immediately.
- Latency: decode inputs appear on the sh_* outputs 1 cycle after capture.
- Forwarding and saturation are combinational in the execute cycle. There is no extra latency.
- Load-use: exactly one bubble per hazard.
  - lu_stall is high for one cycle, while the load sits in this stage.
  - Next cycle the load is in MEM and the dependent instruction is captured.
  - The dependent instruction then forwards the load result from MEM/WB.
- stall and lu_stall together: stall wins. Contents are held, and lu_stall stays asserted as long as the condition holds.
- flush and stall together: flush wins.

## Test plan
- Reset, then capture LSL with shamt_imm = 4 and Rm = 0x0000_0001 -> after 1 cycle: out_valid = 1, sh_control = 00, sh_shamt = 4, sh_data = 0x1.
- Forwarding priority: held Rm = r3, exm_wr, exm_rd = 3, exm_result = 0xAAAA_0000, mwb also writes r3 with 0x5555 -> sh_data = 0xAAAA_0000. Drop exm_wr -> sh_data = 0x5555. Repeat with r15 -> the held data is used.
- Register shift: Rs = 40 -> LSR gives sh_shamt = 0, sh_data = 0; ASR gives sh_shamt = 31; RR gives sh_shamt = 8. Rs = 0x0000_0105 with LSL -> sh_shamt = 5.
- Load-use: load to r2 held, decode reads Rm = r2 -> lu_stall = 1 for one cycle, out_valid = 0 for the next cycle. The dependent instruction then captures and forwards mwb_result.
- stall held 3 cycles -> outputs unchanged. Then flush together with stall -> out_valid = 0 on the next edge.
- Assert rst_n = 0 mid-stream -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/shift_operand_stage_if.sv
// Bundle of the decode-side, writeback-side and shifter-side signals of the
// shift operand pipeline stage. The stage itself uses the slave view; the
// surrounding pipeline (or a bench) uses the master view.
interface shift_operand_stage_if #(
  parameter int WIDTH = 32
);
  // Pipeline control
  logic             stall;
  logic             flush;

  // Decode-side instruction fields
  logic             in_valid;
  logic [1:0]       in_control;
  logic [4:0]       in_shamt_imm;
  logic             in_shamt_reg;
  logic [3:0]       in_rm_addr;
  logic [3:0]       in_rs_addr;
  logic [WIDTH-1:0] in_rm_data;
  logic [WIDTH-1:0] in_rs_data;
  logic             in_is_load;
  logic [3:0]       in_rd;

  // Writeback information from the later stages
  logic             exm_wr;
  logic [3:0]       exm_rd;
  logic [WIDTH-1:0] exm_result;
  logic             mwb_wr;
  logic [3:0]       mwb_rd;
  logic [WIDTH-1:0] mwb_result;

  // Shifter drive and hazard indication
  logic             out_valid;
  logic [1:0]       sh_control;
  logic [4:0]       sh_shamt;
  logic [WIDTH-1:0] sh_data;
  logic             lu_stall;

  modport master (
    output stall, flush,
    output in_valid, in_control, in_shamt_imm, in_shamt_reg,
    output in_rm_addr, in_rs_addr, in_rm_data, in_rs_data,
    output in_is_load, in_rd,
    output exm_wr, exm_rd, exm_result,
    output mwb_wr, mwb_rd, mwb_result,
    input  out_valid, sh_control, sh_shamt, sh_data, lu_stall
  );

  modport slave (
    input  stall, flush,
    input  in_valid, in_control, in_shamt_imm, in_shamt_reg,
    input  in_rm_addr, in_rs_addr, in_rm_data, in_rs_data,
    input  in_is_load, in_rd,
    input  exm_wr, exm_rd, exm_result,
    input  mwb_wr, mwb_rd, mwb_result,
    output out_valid, sh_control, sh_shamt, sh_data, lu_stall
  );
endinterface

// File: rtl/shift_operand_stage.sv
// Decode/execute pipeline register for the shift datapath.
// Holds one shift instruction, forwards its Rm/Rs operands from EX/MEM or
// MEM/WB in the execute cycle, saturates register-specified shift amounts
// and drives the shifter. Also detects load-use hazards against the held
// instruction and inserts a single bubble.
module shift_operand_stage #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  shift_operand_stage_if.slave bus
);

  localparam logic [3:0] PC_ADDR = 4'd15;
  localparam logic [1:0] CTL_LSL = 2'd0;
  localparam logic [1:0] CTL_LSR = 2'd1;
  localparam logic [1:0] CTL_ASR = 2'd2;
  localparam logic [1:0] CTL_RR  = 2'd3;

  // A writeback port hits an operand when it writes that register; the PC is
  // never taken from a writeback port.
  function automatic logic wb_hit(input logic       wr,
                                  input logic [3:0] rd,
                                  input logic [3:0] addr);
    return wr && (rd == addr) && (addr != PC_ADDR);
  endfunction

  // Execute-side operand select: EX/MEM beats MEM/WB beats the held value.
  function automatic logic [WIDTH-1:0] fwd_sel(input logic [3:0]       addr,
                                               input logic [WIDTH-1:0] held,
                                               input logic             ew,
                                               input logic [3:0]       erd,
                                               input logic [WIDTH-1:0] eres,
                                               input logic             mw,
                                               input logic [3:0]       mrd,
                                               input logic [WIDTH-1:0] mres);
    logic [WIDTH-1:0] sel;
    if (wb_hit(ew, erd, addr)) begin
      sel = eres;
    end else if (wb_hit(mw, mrd, addr)) begin
      sel = mres;
    end else begin
      sel = held;
    end
    return sel;
  endfunction

  // Held instruction fields
  logic             valid_q,     valid_d;
  logic [1:0]       control_q,   control_d;
  logic [4:0]       shamt_imm_q, shamt_imm_d;
  logic             shamt_reg_q, shamt_reg_d;
  logic [3:0]       rm_addr_q,   rm_addr_d;
  logic [3:0]       rs_addr_q,   rs_addr_d;
  logic [WIDTH-1:0] rm_data_q,   rm_data_d;
  logic [WIDTH-1:0] rs_data_q,   rs_data_d;
  logic             is_load_q,   is_load_d;
  logic [3:0]       rd_q,        rd_d;

  // Combinational helpers
  logic             lu_stall_s;
  logic [WIDTH-1:0] rm_cap_s;
  logic [WIDTH-1:0] rs_cap_s;
  logic [WIDTH-1:0] rm_fwd_s;
  logic [WIDTH-1:0] rs_fwd_s;
  logic [7:0]       rs_amt_s;
  logic             unused_rs_hi_s;
  logic [1:0]       sh_control_s;
  logic [4:0]       sh_shamt_s;
  logic [WIDTH-1:0] sh_data_s;

  // Load-use hazard: the held load writes a register the decode instruction
  // reads. A flush discards decode anyway, so no bubble is needed then.
  always_comb begin
    lu_stall_s = 1'b0;
    if (bus.flush) begin
      lu_stall_s = 1'b0;
    end else begin
      lu_stall_s = valid_q && is_load_q && bus.in_valid &&
                   ((rd_q == bus.in_rm_addr) ||
                    (bus.in_shamt_reg && (rd_q == bus.in_rs_addr)));
    end
  end

  // Capture bypass: a value being written back this edge is newer than the
  // register-file read data presented by decode.
  always_comb begin
    rm_cap_s = bus.in_rm_data;
    rs_cap_s = bus.in_rs_data;
    if (wb_hit(bus.mwb_wr, bus.mwb_rd, bus.in_rm_addr)) begin
      rm_cap_s = bus.mwb_result;
    end else begin
      rm_cap_s = bus.in_rm_data;
    end
    if (wb_hit(bus.mwb_wr, bus.mwb_rd, bus.in_rs_addr)) begin
      rs_cap_s = bus.mwb_result;
    end else begin
      rs_cap_s = bus.in_rs_data;
    end
  end

  // Next-state selection: flush, then stall, then load-use bubble, then load.
  always_comb begin
    valid_d     = valid_q;
    control_d   = control_q;
    shamt_imm_d = shamt_imm_q;
    shamt_reg_d = shamt_reg_q;
    rm_addr_d   = rm_addr_q;
    rs_addr_d   = rs_addr_q;
    rm_data_d   = rm_data_q;
    rs_data_d   = rs_data_q;
    is_load_d   = is_load_q;
    rd_d        = rd_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (bus.stall) begin
      valid_d = valid_q;
    end else if (lu_stall_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d     = bus.in_valid;
      control_d   = bus.in_control;
      shamt_imm_d = bus.in_shamt_imm;
      shamt_reg_d = bus.in_shamt_reg;
      rm_addr_d   = bus.in_rm_addr;
      rs_addr_d   = bus.in_rs_addr;
      rm_data_d   = rm_cap_s;
      rs_data_d   = rs_cap_s;
      is_load_d   = bus.in_is_load;
      rd_d        = bus.in_rd;
    end
  end

  // Pipeline register; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      control_q   <= 2'd0;
      shamt_imm_q <= 5'd0;
      shamt_reg_q <= 1'b0;
      rm_addr_q   <= 4'd0;
      rs_addr_q   <= 4'd0;
      rm_data_q   <= '0;
      rs_data_q   <= '0;
      is_load_q   <= 1'b0;
      rd_q        <= 4'd0;
    end else begin
      valid_q     <= valid_d;
      control_q   <= control_d;
      shamt_imm_q <= shamt_imm_d;
      shamt_reg_q <= shamt_reg_d;
      rm_addr_q   <= rm_addr_d;
      rs_addr_q   <= rs_addr_d;
      rm_data_q   <= rm_data_d;
      rs_data_q   <= rs_data_d;
      is_load_q   <= is_load_d;
      rd_q        <= rd_d;
    end
  end

  // Execute-cycle operand forwarding for Rm and Rs.
  always_comb begin
    rm_fwd_s = fwd_sel(rm_addr_q, rm_data_q,
                       bus.exm_wr, bus.exm_rd, bus.exm_result,
                       bus.mwb_wr, bus.mwb_rd, bus.mwb_result);
    rs_fwd_s = fwd_sel(rs_addr_q, rs_data_q,
                       bus.exm_wr, bus.exm_rd, bus.exm_result,
                       bus.mwb_wr, bus.mwb_rd, bus.mwb_result);
  end

  // Only the low byte of Rs is a shift amount; the rest is ignored.
  assign rs_amt_s       = rs_fwd_s[7:0];
  assign unused_rs_hi_s = &{1'b0, rs_fwd_s[WIDTH-1:8]};

  // Shifter drive, including saturation of register shift amounts >= 32.
  always_comb begin
    sh_control_s = 2'd0;
    sh_shamt_s   = 5'd0;
    sh_data_s    = '0;
    if (valid_q) begin
      sh_control_s = control_q;
      if (!shamt_reg_q) begin
        sh_shamt_s = shamt_imm_q;
        sh_data_s  = rm_fwd_s;
      end else if ((control_q == CTL_RR) || (rs_amt_s < 8'd32)) begin
        // Rotates are modulo the width; small amounts pass straight through.
        sh_shamt_s = rs_amt_s[4:0];
        sh_data_s  = rm_fwd_s;
      end else if (control_q == CTL_ASR) begin
        // Arithmetic shift by >= 32 equals a shift by 31 (sign fill).
        sh_shamt_s = 5'd31;
        sh_data_s  = rm_fwd_s;
      end else begin
        // LSL/LSR by >= 32 clear the operand entirely.
        case (control_q)
          CTL_LSL, CTL_LSR: begin
            sh_shamt_s = 5'd0;
            sh_data_s  = '0;
          end
          default: begin
            sh_shamt_s = 5'd0;
            sh_data_s  = '0;
          end
        endcase
      end
    end else begin
      sh_control_s = 2'd0;
      sh_shamt_s   = 5'd0;
      sh_data_s    = '0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.sh_control = sh_control_s;
  assign bus.sh_shamt   = sh_shamt_s;
  assign bus.sh_data    = sh_data_s;
  assign bus.lu_stall   = lu_stall_s;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// behavioural model of the stage.
module tb_shift_operand_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  shift_operand_stage_if #(.WIDTH(32)) bus ();

  shift_operand_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctl;
    logic [4:0]  imm;
    logic        sreg;
    logic [3:0]  rm_a;
    logic [31:0] rm_d;
    logic [3:0]  rs_a;
    logic [31:0] rs_d;
    logic        ew;
    logic [3:0]  erd;
    logic [31:0] eres;
    logic        mw;
    logic [3:0]  mrd;
    logic [31:0] mres;
    logic [4:0]  exp_sh;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic        v;
    logic [1:0]  ctl;
    logic [4:0]  imm;
    logic        sreg;
    logic [3:0]  rm_a;
    logic [3:0]  rs_a;
    logic [31:0] rm_d;
    logic [31:0] rs_d;
    logic        ld;
    logic [3:0]  rd;
  } held_t;

  typedef struct {
    logic        v;
    logic [1:0]  ctl;
    logic [4:0]  sh;
    logic [31:0] d;
  } exp_t;

  vec_t  tbl [13];
  held_t m;

  function automatic vec_t mkv(logic [1:0] ctl, logic [4:0] imm, logic sreg,
                               logic [3:0] rm_a, logic [31:0] rm_d,
                               logic [3:0] rs_a, logic [31:0] rs_d,
                               logic ew, logic [3:0] erd, logic [31:0] eres,
                               logic mw, logic [3:0] mrd, logic [31:0] mres,
                               logic [4:0] exp_sh, logic [31:0] exp_d);
    vec_t v;
    v.ctl = ctl; v.imm = imm; v.sreg = sreg;
    v.rm_a = rm_a; v.rm_d = rm_d; v.rs_a = rs_a; v.rs_d = rs_d;
    v.ew = ew; v.erd = erd; v.eres = eres;
    v.mw = mw; v.mrd = mrd; v.mres = mres;
    v.exp_sh = exp_sh; v.exp_d = exp_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_control = 2'd0; bus.in_shamt_imm = 5'd0;
    bus.in_shamt_reg = 1'b0; bus.in_rm_addr = 4'd0; bus.in_rs_addr = 4'd0;
    bus.in_rm_data = 32'd0; bus.in_rs_data = 32'd0;
    bus.in_is_load = 1'b0; bus.in_rd = 4'd0;
    bus.exm_wr = 1'b0; bus.exm_rd = 4'd0; bus.exm_result = 32'd0;
    bus.mwb_wr = 1'b0; bus.mwb_rd = 4'd0; bus.mwb_result = 32'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, ".sh_control"}, 32'(bus.sh_control), 32'd0);
    chk({tag, ".sh_shamt"},   32'(bus.sh_shamt),   32'd0);
    chk({tag, ".sh_data"},    bus.sh_data,         32'd0);
    chk({tag, ".lu_stall"},   32'(bus.lu_stall),   32'd0);
  endtask

  // Reference: value of register addr as seen in execute.
  function automatic logic [31:0] m_fwd(logic [3:0] a, logic [31:0] held);
    if (a == 4'd15) return held;
    if (bus.exm_wr && bus.exm_rd == a) return bus.exm_result;
    if (bus.mwb_wr && bus.mwb_rd == a) return bus.mwb_result;
    return held;
  endfunction

  // Reference: shifter drive for a held instruction.
  function automatic exp_t m_out(held_t h);
    exp_t        e;
    int          n;
    logic [31:0] rm;
    e.v = 1'b0; e.ctl = 2'd0; e.sh = 5'd0; e.d = 32'd0;
    if (h.v) begin
      rm    = m_fwd(h.rm_a, h.rm_d);
      n     = int'(m_fwd(h.rs_a, h.rs_d) & 32'h0000_00FF);
      e.v   = 1'b1;
      e.ctl = h.ctl;
      if (!h.sreg) begin
        e.sh = h.imm; e.d = rm;
      end else if (h.ctl == 2'd3) begin
        e.sh = 5'(n % 32); e.d = rm;
      end else if (n < 32) begin
        e.sh = 5'(n); e.d = rm;
      end else if (h.ctl == 2'd2) begin
        e.sh = 5'd31; e.d = rm;
      end else begin
        e.sh = 5'd0; e.d = 32'd0;
      end
    end
    return e;
  endfunction

  function automatic logic m_lu(held_t h);
    if (bus.flush) return 1'b0;
    return h.v && h.ld && bus.in_valid &&
           (h.rd == bus.in_rm_addr || (bus.in_shamt_reg && h.rd == bus.in_rs_addr));
  endfunction

  function automatic logic [3:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    exp_t  e;
    logic  lu;
    n_vec  = 0;
    n_fail = 0;

    //            ctl   imm  sr rm_a  rm_d          rs_a  rs_d          ew  erd   eres          mw  mrd   mres          sh     data
    tbl[0]  = mkv(2'd0, 5'd4, 1'b0, 4'd1, 32'h0000_0001, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd4, 32'h0000_0001);
    tbl[1]  = mkv(2'd0, 5'd0, 1'b0, 4'd3, 32'h0000_1234, 4'd0, 32'd0, 1'b1, 4'd3, 32'hAAAA_0000, 1'b1, 4'd3, 32'h0000_5555, 5'd0, 32'hAAAA_0000);
    tbl[2]  = mkv(2'd0, 5'd0, 1'b0, 4'd3, 32'h0000_1234, 4'd0, 32'd0, 1'b0, 4'd3, 32'hAAAA_0000, 1'b1, 4'd3, 32'h0000_5555, 5'd0, 32'h0000_5555);
    tbl[3]  = mkv(2'd0, 5'd0, 1'b0, 4'd15, 32'h0000_1234, 4'd0, 32'd0, 1'b1, 4'd15, 32'hAAAA_0000, 1'b1, 4'd15, 32'h0000_5555, 5'd0, 32'h0000_1234);
    tbl[4]  = mkv(2'd1, 5'd9, 1'b1, 4'd1, 32'hFFFF_FFFF, 4'd4, 32'd40, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd0, 32'd0);
    tbl[5]  = mkv(2'd2, 5'd9, 1'b1, 4'd1, 32'h8000_0000, 4'd4, 32'd40, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd31, 32'h8000_0000);
    tbl[6]  = mkv(2'd3, 5'd9, 1'b1, 4'd1, 32'h1234_5678, 4'd4, 32'd40, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd8, 32'h1234_5678);
    tbl[7]  = mkv(2'd0, 5'd9, 1'b1, 4'd1, 32'h1234_5678, 4'd4, 32'h0000_0105, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd5, 32'h1234_5678);
    tbl[8]  = mkv(2'd0, 5'd0, 1'b1, 4'd1, 32'h0000_000F, 4'd5, 32'd0, 1'b1, 4'd5, 32'd3, 1'b0, 4'd0, 32'd0, 5'd3, 32'h0000_000F);
    tbl[9]  = mkv(2'd0, 5'd0, 1'b1, 4'd1, 32'h0000_000F, 4'd5, 32'd32, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd0, 32'd0);
    tbl[10] = mkv(2'd1, 5'd0, 1'b1, 4'd1, 32'h0000_000F, 4'd5, 32'd31, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5'd31, 32'h0000_000F);
    tbl[11] = mkv(2'd2, 5'd0, 1'b1, 4'd2, 32'h0000_0007, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h0000_00FF, 5'd31, 32'h0000_0007);
    tbl[12] = mkv(2'd1, 5'd12, 1'b0, 4'd7, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h0000_F0F0, 5'd12, 32'h0000_F0F0);

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Directed vector table: capture, then drive writeback ports and check.
    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      bus.in_valid = 1'b1;
      bus.in_control = tbl[i].ctl; bus.in_shamt_imm = tbl[i].imm;
      bus.in_shamt_reg = tbl[i].sreg;
      bus.in_rm_addr = tbl[i].rm_a; bus.in_rm_data = tbl[i].rm_d;
      bus.in_rs_addr = tbl[i].rs_a; bus.in_rs_data = tbl[i].rs_d;
      step();
      bus.in_valid = 1'b0;
      bus.exm_wr = tbl[i].ew; bus.exm_rd = tbl[i].erd; bus.exm_result = tbl[i].eres;
      bus.mwb_wr = tbl[i].mw; bus.mwb_rd = tbl[i].mrd; bus.mwb_result = tbl[i].mres;
      #1;
      chk($sformatf("vec%0d.out_valid", i),  32'(bus.out_valid),  32'd1);
      chk($sformatf("vec%0d.sh_control", i), 32'(bus.sh_control), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d.sh_shamt", i),   32'(bus.sh_shamt),   32'(tbl[i].exp_sh));
      chk($sformatf("vec%0d.sh_data", i),    bus.sh_data,         tbl[i].exp_d);
      step();
    end

    // Load-use: load to r2 held, decode reads r2 as Rm.
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_rd = 4'd2; bus.in_rm_addr = 4'd9;
    step();
    bus.in_is_load = 1'b0; bus.in_rd = 4'd4; bus.in_rm_addr = 4'd2;
    bus.in_control = 2'd1; bus.in_shamt_imm = 5'd3; bus.in_rm_data = 32'h0000_DEAD;
    #1;
    chk("lu.stall_hi",  32'(bus.lu_stall),  32'd1);
    chk("lu.load_held", 32'(bus.out_valid), 32'd1);
    step();
    chk("lu.bubble",    32'(bus.out_valid), 32'd0);
    chk("lu.stall_lo",  32'(bus.lu_stall),  32'd0);
    step();
    bus.in_valid = 1'b0;
    bus.mwb_wr = 1'b1; bus.mwb_rd = 4'd2; bus.mwb_result = 32'hCAFE_F00D;
    #1;
    chk("lu.dep_valid", 32'(bus.out_valid),  32'd1);
    chk("lu.dep_ctl",   32'(bus.sh_control), 32'd1);
    chk("lu.dep_shamt", 32'(bus.sh_shamt),   32'd3);
    chk("lu.dep_data",  bus.sh_data,         32'hCAFE_F00D);
    step();

    // Stall for three cycles, then flush together with stall.
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_control = 2'd2; bus.in_shamt_imm = 5'd7;
    bus.in_rm_addr = 4'd6; bus.in_rm_data = 32'h8000_00F0;
    step();
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_control = 2'(c); bus.in_shamt_imm = 5'(c + 1);
      bus.in_rm_data = 32'($urandom);
      step();
      chk("stall.valid", 32'(bus.out_valid),  32'd1);
      chk("stall.ctl",   32'(bus.sh_control), 32'd2);
      chk("stall.shamt", 32'(bus.sh_shamt),   32'd7);
      chk("stall.data",  bus.sh_data,         32'h8000_00F0);
    end
    bus.flush = 1'b1;
    step();
    chk("flush.valid", 32'(bus.out_valid), 32'd0);
    chk("flush.data",  bus.sh_data,        32'd0);
    clear_inputs();

    // Asynchronous reset in the middle of a held instruction.
    bus.in_valid = 1'b1; bus.in_rm_data = 32'h0000_0077; bus.in_shamt_imm = 5'd2;
    step();
    chk("pre_rst.valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    #1;
    rst_n = 1'b1;
    clear_inputs();
    step();

    // Randomized traffic against the reference model (starts from empty).
    m = '{1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.stall        = ($urandom_range(0, 4) == 0);
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.in_control   = 2'($urandom);
      bus.in_shamt_imm = 5'($urandom);
      bus.in_shamt_reg = 1'($urandom);
      bus.in_rm_addr   = pick_addr();
      bus.in_rs_addr   = pick_addr();
      bus.in_rm_data   = $urandom;
      bus.in_rs_data   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      bus.in_is_load   = 1'($urandom);
      bus.in_rd        = 4'($urandom_range(0, 3));
      bus.exm_wr       = 1'($urandom);
      bus.exm_rd       = pick_addr();
      bus.exm_result   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      bus.mwb_wr       = 1'($urandom);
      bus.mwb_rd       = 4'($urandom_range(0, 3));
      bus.mwb_result   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      #1;
      e  = m_out(m);
      lu = m_lu(m);
      chk("rnd.out_valid",  32'(bus.out_valid),  32'(e.v));
      chk("rnd.sh_control", 32'(bus.sh_control), 32'(e.ctl));
      chk("rnd.sh_shamt",   32'(bus.sh_shamt),   32'(e.sh));
      chk("rnd.sh_data",    bus.sh_data,         e.d);
      chk("rnd.lu_stall",   32'(bus.lu_stall),   32'(lu));
      // Advance the model to what the next edge should hold.
      if (bus.flush) begin
        m.v = 1'b0;
      end else if (bus.stall) begin
        m.v = m.v;
      end else if (lu) begin
        m.v = 1'b0;
      end else begin
        m.v    = bus.in_valid;
        m.ctl  = bus.in_control;
        m.imm  = bus.in_shamt_imm;
        m.sreg = bus.in_shamt_reg;
        m.rm_a = bus.in_rm_addr;
        m.rs_a = bus.in_rs_addr;
        m.rm_d = (bus.mwb_wr && bus.mwb_rd == bus.in_rm_addr) ? bus.mwb_result : bus.in_rm_data;
        m.rs_d = (bus.mwb_wr && bus.mwb_rd == bus.in_rs_addr) ? bus.mwb_result : bus.in_rs_data;
        m.ld   = bus.in_is_load;
        m.rd   = bus.in_rd;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
